keypad_scanner: RTL and testbench

- Upstream stage of the keypad decoder. Drives the rows of a 4x4 matrix keypad one at a time and samples the columns.
- Debounces a detected press and encodes it as a 4-bit key code.
- Issues a one-cycle rd_enable strobe with the code held stable, so the decoder loads that key on the same clock edge.
- After each press, waits for a debounced release before scanning again.

---
 rtl/keypad_scanner.sv | 184 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning front end for a 4x4 active-low matrix keypad.
// It drives one row low at a time and samples the columns through a 2-flop
// synchronizer. A press must be debounced before it is encoded as a key code
// and announced with a one-cycle rd_enable strobe. After that, the scanner
// waits for a debounced release before it scans again.
module keypad_scanner #(
    parameter int SETTLE_CYCLES   = 4,   // clocks a row is driven before sampling (>= 3)
    parameter int DEBOUNCE_CYCLES = 8    // stable clocks to accept press / release (>= 2)
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] code,
    output logic       rd_enable,
    output logic       key_down
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES
                                                                  : DEBOUNCE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_VALID,
        ST_WAIT_RELEASE
    } state_t;

    // Registered state.
    state_t           r_state;
    logic [1:0]       r_row;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_col;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_rows;
    logic [3:0]       r_code;
    logic             r_rd_enable;
    logic             r_key_down;

    // Next-state values.
    state_t           w_state_nxt;
    logic [1:0]       w_row_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_col_nxt;
    logic [3:0]       w_code_nxt;
    logic             w_rd_enable_nxt;
    logic             w_key_down_nxt;

    // Column encode. The value is taken from the synchronized columns only.
    logic             w_hit;
    logic [1:0]       w_col_idx;

    // Two-flop synchronizer. The column inputs are asynchronous to clock.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples the values from before the edge.
        if (!reset_n) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= cols;
            r_sync2 <= r_sync1;
        end
    end

    // A key is hit when any synchronized column is low.
    // The lowest-numbered low column wins.
    always_comb begin
        w_hit     = |(~r_sync2);
        w_col_idx = 2'd0;
        if      (!r_sync2[0]) w_col_idx = 2'd0;
        else if (!r_sync2[1]) w_col_idx = 2'd1;
        else if (!r_sync2[2]) w_col_idx = 2'd2;
        else if (!r_sync2[3]) w_col_idx = 2'd3;
    end

    // Next-state and next-output logic for the scan / debounce / release FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path can leave a value unassigned and infer a latch.
        w_state_nxt     = r_state;
        w_row_nxt       = r_row;
        w_cnt_nxt       = r_cnt;
        w_col_nxt       = r_col;
        w_code_nxt      = r_code;
        w_rd_enable_nxt = 1'b0;
        w_key_down_nxt  = r_key_down;

        case (r_state)
            ST_SCAN: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_hit) begin
                        // Keep the same row driven while the press is debounced.
                        w_col_nxt   = w_col_idx;
                        w_state_nxt = ST_DEBOUNCE;
                    end else begin
                        w_row_nxt = r_row + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_DEBOUNCE: begin
                if (w_hit && (w_col_idx == r_col)) begin
                    if (r_cnt == DEBOUNCE_LAST) begin
                        w_code_nxt      = {r_row, r_col};
                        w_rd_enable_nxt = 1'b1;
                        w_key_down_nxt  = 1'b1;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = ST_VALID;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    // Bounce, release or a column change: drop the press and move on.
                    w_row_nxt   = r_row + 2'd1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SCAN;
                end
            end

            ST_VALID: begin
                // rd_enable was set on entry and falls back to 0 here.
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT_RELEASE;
            end

            ST_WAIT_RELEASE: begin
                if (w_hit) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == DEBOUNCE_LAST) begin
                    w_key_down_nxt = 1'b0;
                    w_row_nxt      = 2'd0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ST_SCAN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_row_nxt   = 2'd0;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

    // State and output registers. Reset takes priority over everything.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= ST_SCAN;
            r_row       <= 2'd0;
            r_cnt       <= '0;
            r_col       <= 2'd0;
            r_rows      <= 4'b1110;
            r_code      <= 4'h0;
            r_rd_enable <= 1'b0;
            r_key_down  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_cnt       <= w_cnt_nxt;
            r_col       <= w_col_nxt;
            r_rows      <= ~(4'b0001 << w_row_nxt);
            r_code      <= w_code_nxt;
            r_rd_enable <= w_rd_enable_nxt;
            r_key_down  <= w_key_down_nxt;
        end
    end

    assign rows      = r_rows;
    assign code      = r_code;
    assign rd_enable = r_rd_enable;
    assign key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner. The keypad is modelled
// as a 16-bit pressed-key matrix, and a small register stands in for the decoder.
module tb_keypad_scanner;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] code;
    logic       rd_enable;
    logic       key_down;

    logic [15:0] pressed   = 16'h0000;   // bit 4*row+col
    logic        force_zero = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int n_strobe = 0;
    int dec_updates = 0;
    logic [3:0] dec_q = 4'h0;

    keypad_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cols      (cols),
        .rows      (rows),
        .code      (code),
        .rd_enable (rd_enable),
        .key_down  (key_down)
    );

    always #5 clock = ~clock;

    // Keypad matrix: a column reads low when a pressed key sits on a driven row.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows[r] && pressed[r*4+c]) cols[c] = 1'b0;
        if (force_zero) cols = 4'h0;
    end

    // Downstream decoder stand-in: it loads code on the rd_enable edge.
    always @(posedge clock) begin
        if (rd_enable) begin
            dec_q <= code;
            dec_updates++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Protocol monitor: strobes are single cycles, and code changes only with a strobe.
    logic       prev_rd   = 1'b0;
    logic [3:0] prev_code = 4'h0;
    logic       prev_rst_n = 1'b0;
    always @(negedge clock) begin
        if (reset_n && prev_rst_n) begin
            if (rd_enable) begin
                n_strobe++;
                check("rd_single", {31'd0, prev_rd}, 32'd0);
            end
            if (code !== prev_code) check("code_hold", {31'd0, rd_enable}, 32'd1);
        end
        prev_rd    = rd_enable;
        prev_code  = code;
        prev_rst_n = reset_n;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_strobe(input string tag, input int budget);
        int k;
        k = 0;
        while (!rd_enable && k < budget) begin
            step(1);
            k++;
        end
        check({tag, "_strobe_seen"}, {31'd0, rd_enable}, 32'd1);
    endtask

    task automatic wait_release(input string tag, input int budget);
        int k;
        k = 0;
        while (key_down && k < budget) begin
            step(1);
            k++;
        end
        check({tag, "_released"}, {31'd0, key_down}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dbase;

        // Reset with the columns forced low.
        reset_n    = 1'b0;
        force_zero = 1'b1;
        step(3);
        check("rst_rows", {28'd0, rows}, 32'hE);
        check("rst_code", {28'd0, code}, 32'h0);
        check("rst_rd",   {31'd0, rd_enable}, 32'd0);
        check("rst_kd",   {31'd0, key_down}, 32'd0);
        force_zero = 1'b0;
        reset_n    = 1'b1;

        // Idle scan: each row is driven for 4 clocks.
        step(3);
        check("scan_r0", {28'd0, rows}, 32'hE);
        step(1);
        check("scan_r1", {28'd0, rows}, 32'hD);
        step(4);
        check("scan_r2", {28'd0, rows}, 32'hB);
        step(4);
        check("scan_r3", {28'd0, rows}, 32'h7);
        step(4);
        check("scan_wrap", {28'd0, rows}, 32'hE);

        // Clean press on row 2 col 1.
        base = n_strobe;
        pressed = 16'h0200;
        wait_strobe("clean", 100);
        check("clean_code", {28'd0, code}, 32'h9);
        check("clean_kd",   {31'd0, key_down}, 32'd1);
        check("clean_rows", {28'd0, rows}, 32'hB);
        step(1);
        check("clean_rd_low", {31'd0, rd_enable}, 32'd0);
        step(50);
        check("clean_held_rows", {28'd0, rows}, 32'hB);
        check("clean_one_strobe", n_strobe - base, 32'd1);
        pressed = 16'h0000;
        step(9);
        check("clean_kd_hold", {31'd0, key_down}, 32'd1);
        step(1);
        check("clean_kd_fall", {31'd0, key_down}, 32'd0);
        check("clean_rescan", {28'd0, rows}, 32'hE);

        // Bounce on row 1 col 3, then a steady hold.
        base = n_strobe;
        for (int i = 0; i < 10; i++) begin
            pressed[7] = ~pressed[7];
            step(3);
        end
        check("bounce_no_strobe", n_strobe - base, 32'd0);
        pressed = 16'h0080;
        wait_strobe("bounce", 100);
        check("bounce_code", {28'd0, code}, 32'h7);
        step(30);
        check("bounce_one_strobe", n_strobe - base, 32'd1);
        pressed = 16'h0000;
        wait_release("bounce", 50);

        // Row 3, cols 0 and 2 held together: the lowest column wins.
        base = n_strobe;
        pressed = 16'h5000;
        step(200);
        check("two_col_strobes", n_strobe - base, 32'd1);
        check("two_col_code", {28'd0, code}, 32'hC);
        check("two_col_kd", {31'd0, key_down}, 32'd1);
        pressed = 16'h0000;
        wait_release("two_col", 50);
        step(20);
        check("two_col_after", n_strobe - base, 32'd1);

        // Reset at DEBOUNCE count 5 with row 0 col 2 held.
        base = n_strobe;
        reset_n = 1'b0;
        pressed = 16'h0004;
        step(2);
        reset_n = 1'b1;
        step(9);
        reset_n = 1'b0;
        step(1);
        check("midrst_rows", {28'd0, rows}, 32'hE);
        check("midrst_code", {28'd0, code}, 32'h0);
        check("midrst_rd",   {31'd0, rd_enable}, 32'd0);
        check("midrst_kd",   {31'd0, key_down}, 32'd0);
        reset_n = 1'b1;
        step(1);
        check("midrst_no_strobe", n_strobe - base, 32'd0);
        wait_strobe("midrst", 60);
        check("midrst_code_again", {28'd0, code}, 32'h2);
        step(10);
        check("midrst_one_strobe", n_strobe - base, 32'd1);
        pressed = 16'h0000;
        wait_release("midrst", 50);

        // Decoder handoff: press keys 0, 5 and 9 in turn.
        dbase = dec_updates;
        pressed = 16'h0001;
        wait_strobe("dec0", 100);
        step(20);
        pressed = 16'h0000;
        wait_release("dec0", 50);
        check("dec0_value", {28'd0, dec_q}, 32'h0);
        check("dec0_updates", dec_updates - dbase, 32'd1);

        pressed = 16'h0020;
        wait_strobe("dec5", 100);
        step(20);
        pressed = 16'h0000;
        wait_release("dec5", 50);
        check("dec5_value", {28'd0, dec_q}, 32'h5);
        check("dec5_updates", dec_updates - dbase, 32'd2);

        pressed = 16'h0200;
        wait_strobe("dec9", 100);
        step(20);
        pressed = 16'h0000;
        wait_release("dec9", 50);
        step(30);
        check("dec9_value", {28'd0, dec_q}, 32'h9);
        check("dec9_updates", dec_updates - dbase, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
